inverse_matrix_ctrl: RTL and testbench
======================================

Name: inverse_matrix_ctrl

Overview:
- Sequencer for 3x3 integer matrix inversion by the adjugate method.
- Accepts 9 signed elements serially into an internal register file.
- Time-multiplexes one registered signed multiplier to compute all 9 cofactors, then the determinant.
- Streams the adjugate out with a valid/ready handshake; the downstream divider forms inv = adj/det and takes det and singular from this block.

Parameters:
- W, 8, element width (signed two's complement)
- CW, 2*W+1, cofactor/adjugate output width (derived, not overridable)
- DW, 3*W+3, determinant width (derived, not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new inversion; honoured only in IDLE
- in_valid  input  1  in_data holds a matrix element
- in_ready  output  1  block accepts an element this cycle
- in_data  input  W  element, row-major a00,a01,...,a22
- out_valid  output  1  out_data holds an adjugate element
- out_ready  input  1  downstream accepts out_data
- out_data  output  CW  adjugate element, row-major adj00..adj22
- det  output  DW  determinant, held stable from CHECK until the next start
- singular  output  1  det==0, held until the next start
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at end of operation

Behaviour:
- Reset (async, rst_n low): state=IDLE; in_ready, out_valid, done, singular, busy = 0; det=0; out_data=0; counters and register file cleared.
- Reset mid-operation aborts immediately with no done pulse; the next start works normally.
- IDLE: start=1 -> LOAD; clear singular and det. start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready beat writes a[idx], idx 0..8.
  - Gaps in in_valid are allowed.
  - After beat 9 -> COF.
- COF: 18 cycles, two multiplies per cofactor, i,j in row-major order, one product per cycle.
  - C[i][j] = a[i+1][j+1]*a[i+2][j+2] - a[i+1][j+2]*a[i+2][j+1], indices mod 3. The cyclic form embeds the sign.
  - Products are 2W signed. The difference is sign-extended to CW, so no overflow is possible.
  - Then -> DET.
- DET: 3 cycles.
  - acc += a[0][j]*C[0][j], j=0..2.
  - Product width 3W+1; acc is DW wide, so no overflow.
  - Then -> CHECK.
- CHECK: 1 cycle. det<=acc; singular<=(acc==0).
  - singular -> DONE.
  - else -> OUT.
- OUT:
  - out_valid=1; out_data = adj[r][c] = C[c][r] (transpose), k=0..8 row-major.
  - k advances only on out_valid&out_ready. out_data is stable while out_ready=0.
  - After beat 9 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Latency: start sampled at edge T0 with in_valid held high:
  - elements accepted at T1..T9
  - COF T10..T27, DET T28..T30, CHECK T31
  - out_valid high after T31
  - with out_ready=1, done high after T40
- The single multiplier is shared between COF and DET; it is never active in any other state.
- in_ready and out_valid are never high simultaneously.

Decomposition:
- Package inverse_matrix_pkg:
  - state enum: IDLE, LOAD, COF, DET, CHECK, OUT, DONE
  - localparam N=3, NELEM=9
  - constant lookup of operand index pairs for the 18 COF steps
- Sub-module inverse_matrix_mul: registered signed multiplier, parameterised operand widths, 1-cycle latency. The controller must account for this latency in COF/DET accumulation.

Test Plan:
- Identity matrix -> adj = identity, det=1, singular=0, 9 output beats, done once.
- [[2,0,0],[0,3,0],[0,0,4]] -> adj diag (12,8,6), other entries 0, det=24.
- [[1,2,3],[0,1,4],[5,6,0]] with random in_valid gaps and random out_ready backpressure -> adj = [[-24,18,5],[20,-15,-4],[-5,4,1]], det=1; out_data stable while stalled.
- [[1,2,3],[4,5,6],[7,8,9]] -> det=0, singular=1, out_valid never asserted, done pulses after CHECK.
- All elements -128 (W=8), then [[-128,127,0],[0,-128,127],[127,0,-128]] -> all-equal case gives adj all 0, det=0, singular=1; second case checked against the reference model with no width overflow.
- Assert rst_n low during COF, release, start pulse during LOAD of a new run -> no done or out_valid from the aborted run; the mid-run start is ignored; the new run produces the correct identity result.

Source files
------------

// File: rtl/inverse_matrix_pkg.sv
// Shared types and constant tables for the 3x3 adjugate/determinant sequencer.
// The COF tables list the two operand pairs for each cofactor in row-major cofactor order.
package inverse_matrix_pkg;

  localparam int N     = 3;
  localparam int NELEM = N * N;
  localparam int NSTEP = 2 * NELEM;

  typedef enum logic [2:0] {IDLE, LOAD, COF, DET, CHECK, OUT, DONE} state_e;

  // What the multiplier output register currently holds, so it can be retired a cycle later.
  typedef enum logic [1:0] {P_NONE, P_COF_A, P_COF_B, P_DET} pend_e;

  typedef logic [3:0] idx_t;

  // C[i][j] = a[i+1][j+1]*a[i+2][j+2] - a[i+1][j+2]*a[i+2][j+1] (indices mod 3), flattened row-major
  localparam idx_t COF_A [NSTEP] = '{
    4'd4, 4'd5, 4'd5, 4'd3, 4'd3, 4'd4,
    4'd7, 4'd8, 4'd8, 4'd6, 4'd6, 4'd7,
    4'd1, 4'd2, 4'd2, 4'd0, 4'd0, 4'd1
  };
  localparam idx_t COF_B [NSTEP] = '{
    4'd8, 4'd7, 4'd6, 4'd8, 4'd7, 4'd6,
    4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0,
    4'd5, 4'd4, 4'd3, 4'd5, 4'd4, 4'd3
  };

  // adj[r][c] = C[c][r]: cofactor index emitted on output beat k
  localparam idx_t ADJ_SRC [NELEM] = '{
    4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8
  };

endpackage

// File: rtl/inverse_matrix_mul.sv
// Registered signed multiplier with one cycle of latency; the product register
// only updates while en is high so it is idle outside the arithmetic phases.
module inverse_matrix_mul #(
  parameter int AW = 8,
  parameter int BW = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [AW-1:0]     a,
  input  logic signed [BW-1:0]     b,
  output logic signed [AW+BW-1:0]  p
);

  localparam int PW = AW + BW;

  logic signed [PW-1:0] a_ext, b_ext, p_d, p_q;

  always_comb begin
    a_ext = PW'(a);
    b_ext = PW'(b);
    p_d   = en ? (a_ext * b_ext) : p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/inverse_matrix_ctrl.sv
// Adjugate-method 3x3 inversion sequencer: loads 9 elements, forms cofactors and the
// determinant on one shared multiplier, then streams the transposed cofactors out.
module inverse_matrix_ctrl
  import inverse_matrix_pkg::*;
#(
  parameter  int W  = 8,
  localparam int CW = 2*W + 1,
  localparam int DW = 3*W + 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [CW-1:0] out_data,
  output logic signed [DW-1:0] det,
  output logic                 singular,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = W + CW;

  state_e               state_q, state_d;
  logic [4:0]           step_q, step_d;
  logic signed [W-1:0]  a_q [NELEM];
  logic signed [W-1:0]  a_d [NELEM];
  logic signed [CW-1:0] c_q [NELEM];
  logic signed [CW-1:0] c_d [NELEM];
  logic signed [CW-1:0] tmp_q, tmp_d;
  logic signed [DW-1:0] acc_q, acc_d, acc_sum;
  pend_e                pend_q, pend_d;
  logic [3:0]           pidx_q, pidx_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [CW-1:0] out_data_q, out_data_d;
  logic signed [DW-1:0] det_q, det_d;
  logic                 singular_q, singular_d;
  logic                 done_q, done_d;

  logic                 mul_en;
  logic signed [W-1:0]  mul_a;
  logic signed [CW-1:0] mul_b;
  logic signed [PW-1:0] mul_p;

  always_comb begin
    mul_en = 1'b0;
    mul_a  = '0;
    mul_b  = '0;
    if (state_q == COF) begin
      mul_en = 1'b1;
      mul_a  = a_q[COF_A[step_q]];
      mul_b  = CW'(a_q[COF_B[step_q]]);
    end else if (state_q == DET) begin
      mul_en = 1'b1;
      mul_a  = a_q[step_q[3:0]];
      mul_b  = c_q[step_q[3:0]];
    end
  end

  inverse_matrix_mul #(.AW(W), .BW(CW)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mul_en),
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    c_d         = c_q;
    tmp_d       = tmp_q;
    pend_d      = P_NONE;
    pidx_d      = pidx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    det_d       = det_q;
    singular_d  = singular_q;
    done_d      = 1'b0;

    // Retire last cycle's product; the final DET product is folded in combinationally for CHECK.
    acc_sum = acc_q + ((pend_q == P_DET) ? DW'(mul_p) : '0);
    acc_d   = acc_sum;
    case (pend_q)
      P_COF_A: tmp_d = CW'(mul_p);
      P_COF_B: c_d[pidx_q] = tmp_q - CW'(mul_p);
      default: ;
    endcase

    if (mul_en) begin
      pend_d = (state_q == COF) ? (step_q[0] ? P_COF_B : P_COF_A) : P_DET;
      pidx_d = step_q[4:1];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          step_d     = '0;
          in_ready_d = 1'b1;
          det_d      = '0;
          singular_d = 1'b0;
          acc_d      = '0;
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          a_d[step_q[3:0]] = in_data;
          if (step_q == 5'd8) begin
            state_d    = COF;
            step_d     = '0;
            in_ready_d = 1'b0;
          end else begin
            step_d = step_q + 5'd1;
          end
        end
      end
      COF: begin
        if (step_q == 5'd17) begin
          state_d = DET;
          step_d  = '0;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      DET: begin
        if (step_q == 5'd2) begin
          state_d = CHECK;
          step_d  = '0;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      CHECK: begin
        det_d      = acc_sum;
        singular_d = (acc_sum == '0);
        if (acc_sum == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = OUT;
          step_d      = '0;
          out_valid_d = 1'b1;
          out_data_d  = c_q[ADJ_SRC[0]];
        end
      end
      OUT: begin
        if (out_ready) begin
          if (step_q == 5'd8) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            step_d     = step_q + 5'd1;
            out_data_d = c_q[ADJ_SRC[step_q[3:0] + 4'd1]];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      for (int i = 0; i < NELEM; i++) begin
        a_q[i] <= '0;
        c_q[i] <= '0;
      end
      tmp_q       <= '0;
      acc_q       <= '0;
      pend_q      <= P_NONE;
      pidx_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      det_q       <= '0;
      singular_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      c_q         <= c_d;
      tmp_q       <= tmp_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      pidx_q      <= pidx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      det_q       <= det_d;
      singular_q  <= singular_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign det       = det_q;
  assign singular  = singular_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_inverse_matrix_ctrl.sv
// Randomised bench for inverse_matrix_ctrl: a cofactor/Sarrus reference model predicts
// the adjugate stream, determinant and singular flag for every matrix driven in.
module tb_inverse_matrix_ctrl;

  localparam int W  = 8;
  localparam int CW = 2*W + 1;
  localparam int DW = 3*W + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [W-1:0] in_data = '0;
  logic in_ready, out_valid, singular, busy, done;
  logic signed [CW-1:0] out_data;
  logic signed [DW-1:0] det;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int bp_pct = 0;

  longint exp_q[$];
  longint exp_det = 0;
  bit     exp_sing = 1'b0;
  bit     exp_active = 1'b0;
  int     done_seen = 0;
  int     done_base = 0;
  int     beats = 0;
  int     first_beat_cyc = -1;
  int     done_cyc = -1;
  bit     stalled_prev = 1'b0;
  bit     done_prev = 1'b0;
  logic signed [CW-1:0] held_data = '0;

  inverse_matrix_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .det       (det),
    .singular  (singular),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: signed minors with checkerboard sign, adjugate = transpose, det by Sarrus.
  function automatic void model(input int m[9], output longint adj[9], output longint d);
    longint cof[9];
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int r0 = (i == 0) ? 1 : 0;
        int r1 = (i == 2) ? 1 : 2;
        int c0 = (j == 0) ? 1 : 0;
        int c1 = (j == 2) ? 1 : 2;
        longint minor = longint'(m[r0*3+c0]) * m[r1*3+c1] - longint'(m[r0*3+c1]) * m[r1*3+c0];
        cof[i*3+j] = ((i + j) % 2 == 0) ? minor : -minor;
      end
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        adj[r*3+c] = cof[c*3+r];
    d = longint'(m[0]) * m[4] * m[8] + longint'(m[1]) * m[5] * m[6] + longint'(m[2]) * m[3] * m[7]
      - longint'(m[2]) * m[4] * m[6] - longint'(m[0]) * m[5] * m[7] - longint'(m[1]) * m[3] * m[8];
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 out_ready = (bp_pct == 0) || ($urandom_range(99) >= bp_pct);
    end
  end

  // Single compare process: handshake beats, stall stability, exclusivity and completion.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
      done_prev    = 1'b0;
    end else begin
      checkOutput("in_ready/out_valid exclusive", longint'(in_ready && out_valid), 0);
      if (out_valid) begin
        checkOutput("out_valid only for nonsingular run", longint'(exp_sing || !exp_active), 0);
        if (stalled_prev) checkOutput("out_data stable under stall", out_data, held_data);
        if (out_ready) begin
          checkOutput("output beat expected", longint'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) checkOutput($sformatf("adj beat %0d", beats), out_data, exp_q.pop_front());
          if (beats == 0) first_beat_cyc = cyc;
          beats++;
        end
        stalled_prev = !out_ready;
        held_data    = out_data;
      end else begin
        stalled_prev = 1'b0;
      end
      if (done) begin
        checkOutput("done expected", longint'(exp_active), 1);
        checkOutput("beats left at done", exp_q.size(), 0);
        checkOutput("det at done", det, exp_det);
        checkOutput("singular at done", longint'(singular), longint'(exp_sing));
        checkOutput("done single cycle", longint'(done_prev), 0);
        done_cyc   = cyc;
        done_seen++;
        exp_active = 1'b0;
      end
      done_prev = done;
    end
  end

  task automatic applyStimulus(input int m[9], input int gap_pct, input bit mid_start);
    longint adj[9];
    longint d;
    int k;
    int guard;
    bit fire;
    model(m, adj, d);
    exp_q.delete();
    exp_det  = d;
    exp_sing = (d == 0);
    if (d != 0) for (int i = 0; i < 9; i++) exp_q.push_back(adj[i]);
    beats = 0;
    first_beat_cyc = -1;
    done_cyc = -1;
    done_base = done_seen;
    exp_active = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
    checkOutput("det cleared at start", det, 0);
    checkOutput("singular cleared at start", longint'(singular), 0);
    checkOutput("busy after start", longint'(busy), 1);
    k = 0;
    guard = 0;
    while (k < 9 && guard < 2000) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = W'(m[k]);
      end
      start = mid_start && (k == 4);
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) k++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    checkOutput("elements accepted", k, 9);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_seen == done_base && n < bound) begin
      @(posedge clk);
      n++;
    end
    checkOutput("done within bound", done_seen, done_base + 1);
  endtask

  task automatic run_matrix(input int m[9], input int gap_pct, input int bp, input bit lat);
    bp_pct = bp;
    applyStimulus(m, gap_pct, 1'b0);
    wait_done(600);
    repeat (2) @(negedge clk);
    checkOutput("det held after done", det, exp_det);
    checkOutput("singular held after done", longint'(singular), longint'(exp_sing));
    checkOutput("idle after done", longint'(busy), 0);
    if (lat) begin
      checkOutput("done latency", done_cyc - t0, exp_sing ? 31 : 40);
      if (!exp_sing) checkOutput("first beat latency", first_beat_cyc - t0, 31);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int mt[9];
    int ident[9];
    longint adj[9];
    longint d;
    int base;

    ident = '{1, 0, 0, 0, 1, 0, 0, 0, 1};

    mt = '{1, 2, 3, 0, 1, 4, 5, 6, 0};
    model(mt, adj, d);
    checkOutput("model pin det", d, 1);
    checkOutput("model pin adj00", adj[0], -24);
    checkOutput("model pin adj01", adj[1], 18);
    checkOutput("model pin adj10", adj[3], 20);
    checkOutput("model pin adj21", adj[7], 4);
    mt = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
    model(mt, adj, d);
    checkOutput("model pin diag det", d, 24);
    checkOutput("model pin diag adj00", adj[0], 12);
    checkOutput("model pin diag adj22", adj[8], 6);
    mt = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    model(mt, adj, d);
    checkOutput("model pin singular det", d, 0);

    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", longint'(in_ready), 0);
    checkOutput("reset out_valid", longint'(out_valid), 0);
    checkOutput("reset done", longint'(done), 0);
    checkOutput("reset singular", longint'(singular), 0);
    checkOutput("reset busy", longint'(busy), 0);
    checkOutput("reset det", det, 0);
    checkOutput("reset out_data", out_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] identity");
    run_matrix(ident, 0, 0, 1'b1);
    $display("[TB] diagonal 2,3,4");
    mt = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
    run_matrix(mt, 0, 0, 1'b1);
    $display("[TB] det 1 matrix with gaps and backpressure");
    mt = '{1, 2, 3, 0, 1, 4, 5, 6, 0};
    run_matrix(mt, 40, 50, 1'b0);
    $display("[TB] singular 1..9");
    mt = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_matrix(mt, 0, 0, 1'b1);
    $display("[TB] all -128");
    mt = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    run_matrix(mt, 0, 0, 1'b1);
    $display("[TB] extreme mixed");
    mt = '{-128, 127, 0, 0, -128, 127, 127, 0, -128};
    run_matrix(mt, 20, 30, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 9; i++) mt[i] = int'($urandom_range(255)) - 128;
      $display("[TB] random matrix %0d", t);
      run_matrix(mt, int'($urandom_range(50)), int'($urandom_range(60)), 1'b0);
    end

    $display("[TB] abort during COF");
    bp_pct = 0;
    applyStimulus(ident, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    exp_active = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", longint'(busy), 0);
    checkOutput("abort out_valid", longint'(out_valid), 0);
    checkOutput("abort det", det, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = done_seen;
    repeat (60) @(posedge clk);
    checkOutput("no done from aborted run", done_seen, base);

    $display("[TB] identity after abort with ignored start in LOAD");
    applyStimulus(ident, 0, 1'b1);
    wait_done(600);
    @(negedge clk);
    checkOutput("post-abort det", det, 1);
    checkOutput("post-abort beats", beats, 9);
    checkOutput("post-abort done latency", done_cyc - t0, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
